mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 58 +++++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, requester ids and the
// word-alignment width applied to outgoing memory addresses.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    // Low address bits dropped to form a word address.
    localparam int WORD_ALIGN = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the fetch/data arbiter. Default build is fixed data
// priority with a fetch starvation counter; MEM_ARB_RR_EN selects round-robin.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic arb_en,
    input  logic if_req,
    input  logic d_req,
    output logic pick_if,
    output logic pick_d
);

`ifdef MEM_ARB_RR_EN
    req_id_t last;

    // On conflict the port that did not win last time goes first.
    always_comb begin
        pick_d  = d_req && (!if_req || last == REQ_IF);
        pick_if = if_req && !pick_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last <= REQ_IF;
        else if (arb_en && (pick_if || pick_d))
            last <= pick_d ? REQ_D : REQ_IF;
    end
`else
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve;
    logic          starved;

    assign starved = (starve == CW'(STARVE_LIMIT));

    always_comb begin
        pick_d  = d_req && !(if_req && starved);
        pick_if = if_req && !pick_d;
    end

    // Only lost arbitrations count; the counter saturates at the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            starve <= '0;
        else if (arb_en) begin
            if (pick_if)
                starve <= '0;
            else if (if_req && pick_d && !starved)
                starve <= starve + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-outstanding memory port.
// Build option MEM_ARB_RR_EN switches arbitration to round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [ADDR_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [ADDR_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [ADDR_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    input  logic [ADDR_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t        state;
    req_id_t           owner;
    logic              arb_en;
    logic              pick_if;
    logic              pick_d;
    logic [ADDR_W-1:0] sel_addr;

    // Grants are combinational but only ever leave IDLE, and never in reset.
    assign arb_en   = (state == ST_IDLE) && reset_n;
    assign if_gnt   = arb_en && pick_if;
    assign d_gnt    = arb_en && pick_d;
    assign sel_addr = d_gnt ? d_addr : if_addr;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk     (clk),
        .reset_n (reset_n),
        .arb_en  (arb_en),
        .if_req  (if_req),
        .d_req   (d_req),
        .pick_if (pick_if),
        .pick_d  (pick_d)
    );

    // mem_* registers double as the latched request for the transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            owner     <= REQ_IF;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (if_gnt || d_gnt) begin
                        owner     <= d_gnt ? REQ_D : REQ_IF;
                        mem_en    <= 1'b1;
                        mem_we    <= d_gnt && d_we;
                        mem_addr  <= {sel_addr[ADDR_W-1:WORD_ALIGN], {WORD_ALIGN{1'b0}}};
                        mem_wdata <= d_gnt ? d_wdata : '0;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ready) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        // Writes are acked with rvalid but leave rdata alone.
                        if (!mem_we) begin
                            if (owner == REQ_D) d_rdata  <= mem_rdata;
                            else                if_rdata <= mem_rdata;
                        end
                        if_rvalid <= (owner == REQ_IF);
                        d_rvalid  <= (owner == REQ_D);
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if_rvalid <= 1'b0;
                    d_rvalid  <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: expected responses are queued when a
// request is issued and checked when the matching rvalid pulse appears.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [AW-1:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [AW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(LIM), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    typedef struct {
        logic          is_d;
        logic [AW-1:0] rdata;
    } sb_t;

    sb_t           sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [AW-1:0] m_if_rd = '0;
    logic [AW-1:0] m_d_rd  = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Response monitor: every rvalid must match the oldest queued expectation.
    always @(negedge clk) begin : mon
        sb_t e;
        if (reset_n && (if_rvalid || d_rvalid)) begin
            if (sb.size() == 0)
                chk("spurious_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd0);
            else begin
                e = sb.pop_front();
                chk("rv_if", {31'b0, if_rvalid}, {31'b0, !e.is_d});
                chk("rv_d",  {31'b0, d_rvalid},  {31'b0, e.is_d});
                if (e.is_d) begin
                    chk("d_rdata", d_rdata, e.rdata);
                    chk("if_rdata_kept", if_rdata, m_if_rd);
                    m_d_rd = e.rdata;
                end else begin
                    chk("if_rdata", if_rdata, e.rdata);
                    chk("d_rdata_kept", d_rdata, m_d_rd);
                    m_if_rd = e.rdata;
                end
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {26'b0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we}, 32'd0);
        chk({tag, "_maddr"}, mem_addr, 32'd0);
        chk({tag, "_mwdata"}, mem_wdata, 32'd0);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    task automatic wait_gnt(output logic gi, output logic gd, output int cyc);
        gi = 1'b0; gd = 1'b0; cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc = i + 1;
            if (if_gnt || d_gnt) begin
                gi = if_gnt;
                gd = d_gnt;
                return;
            end
        end
        chk("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk(tag, sb.size(), 32'd0);
    endtask

    // One isolated transaction from IDLE with dly cycles of mem_ready low.
    task automatic xact(input logic is_d, input logic we, input logic [AW-1:0] addr,
                        input logic [AW-1:0] wdata, input logic [AW-1:0] rdata,
                        input int dly, input string tag);
        logic gi, gd;
        int   c;
        @(posedge clk); #1;
        mem_rdata = rdata;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        sb.push_back('{is_d, (is_d && we) ? m_d_rd : rdata});
        wait_gnt(gi, gd, c);
        chk({tag, "_gnt"}, {30'b0, gi, gd}, {30'b0, !is_d, is_d});
        chk({tag, "_gnt_lat"}, c, 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        for (int i = 0; i <= dly; i++) begin
            mem_ready = (i == dly);
            @(negedge clk);
            chk({tag, "_mem_en"}, {31'b0, mem_en}, 32'd1);
            chk({tag, "_mem_we"}, {31'b0, mem_we}, {31'b0, is_d && we});
            chk({tag, "_mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
            if (we) chk({tag, "_mem_wdata"}, mem_wdata, wdata);
            chk({tag, "_rv_early"}, {30'b0, if_rvalid, d_rvalid}, 32'd0);
            chk({tag, "_no_gnt"}, {30'b0, if_gnt, d_gnt}, 32'd0);
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_rv"}, {30'b0, if_rvalid, d_rvalid}, {30'b0, !is_d, is_d});
        chk({tag, "_mem_en_off"}, {31'b0, mem_en}, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic gi, gd, exp_if;
        int   c;
        int   scnt;
        logic last_was_d;

        // Reset state, with requests present to show grants stay low.
        if_req = 1'b1; d_req = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("rst");
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        reset_n = 1'b1;

        // Minimum-latency fetch, data read, delayed data write, unaligned fetch.
        xact(1'b0, 1'b0, 32'h0000_0004, 32'h0, 32'hE280_0008, 0, "fetch");
        xact(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678, 0, "dread");
        xact(1'b1, 1'b1, 32'h0000_0013, 32'hDEAD_BEEF, 32'hCAFE_F00D, 3, "dwrite");
        xact(1'b0, 1'b0, 32'h0000_0101, 32'h0, 32'h5A5A_0101, 1, "fetch2");
        drain("drain_single");

        // Continuous conflict; last grant was fetch so data wins first.
        scnt = 0;
        last_was_d = 1'b0;
        @(posedge clk); #1;
        mem_ready = 1'b1;
        if_req = 1'b1; if_addr = 32'h0000_0200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
        for (int k = 0; k < 10; k++) begin
            mem_rdata = 32'hA500_0000 + k;
`ifdef MEM_ARB_RR_EN
            exp_if = last_was_d;
            last_was_d = !exp_if;
`else
            exp_if = (scnt == LIM);
            if (exp_if) scnt = 0;
            else if (scnt < LIM) scnt++;
`endif
            wait_gnt(gi, gd, c);
            chk("conflict_gnt", {30'b0, gi, gd}, {30'b0, exp_if, !exp_if});
            chk("conflict_gap", c, (k == 0) ? 32'd1 : 32'd2);
            sb.push_back('{!exp_if, mem_rdata});
            repeat (2) begin @(posedge clk); #1; end
        end
        if_req = 1'b0; d_req = 1'b0;
        drain("drain_conflict");

        // Reset while a fetch is waiting in ACCESS aborts it.
        @(posedge clk); #1;
        mem_ready = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_0040;
        wait_gnt(gi, gd, c);
        chk("abort_gnt", {30'b0, gi, gd}, 32'd2);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        chk("abort_mem_en", {31'b0, mem_en}, 32'd1);
        #2 reset_n = 1'b0;
        #1 chk_zero("abort_async");
        sb.delete();
        m_if_rd = '0;
        m_d_rd  = '0;
        @(negedge clk);
        chk_zero("abort_hold");
        @(posedge clk); #1;
        mem_ready = 1'b1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_quiet", {29'b0, if_rvalid, d_rvalid, mem_en}, 32'd0);
        end
        mem_ready = 1'b0;
        xact(1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h0BAD_F00D, 1, "fresh");
        drain("drain_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
